bus_cycle_sequencer: RTL and testbench

Parametrised external memory bus sequencer that replaces the core's fixed four-phase bus handling. It turns a single-cycle request from the core into a SETUP / STROBE / HOLD bus cycle with active-low strobes, per-byte-lane write enables, programmable wait states and an external READY stretch. It sits between the core's load/store/fetch logic and the board-level ADDR_BUF / DOUT_BUF / DIN buffers.

---
 rtl/bus_cycle_sequencer_pkg.sv | 22 ++
 rtl/bus_wait_counter.sv | 29 ++
 rtl/bus_cycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared constants for the external memory bus sequencer: bus cycle state
// encodings, default parameter values and a counter-width helper.
package bus_cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_STROBE = 2'd2,
    BUS_HOLD   = 2'd3
  } bus_state_t;

  localparam int BUS_ADDR_W  = 16;
  localparam int BUS_DATA_W  = 16;
  localparam int BUS_WAIT_W  = 3;
  localparam int BUS_TIMEOUT = 64;

  // Width needed to hold n-1 (a down-counter that starts at n-1 and ends at 0).
  function automatic int bus_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag. Used for STROBE wait states and,
// when BUS_TIMEOUT_EN is defined, for the STROBE timeout.
module bus_wait_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// External memory bus sequencer: turns a one-cycle core request into a
// SETUP / STROBE / HOLD bus cycle with active-low strobes, byte-lane write
// enables, programmable wait states and a READY stretch.
// Optional feature macro: BUS_TIMEOUT_EN (STROBE abort after TIMEOUT cycles).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// BUS_IDLE   | bus released, waiting for REQ
// BUS_SETUP  | address (and write data) driven, strobes high, 1 cycle
// BUS_STROBE | RDN or WRN asserted until wait count is 0 and READY is 1
// BUS_HOLD   | strobes high, buses still driven, ACK pulse, 1 cycle
module bus_cycle_sequencer
  import bus_cycle_sequencer_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int WAIT_W  = BUS_WAIT_W,
  parameter int TIMEOUT = BUS_TIMEOUT,
  localparam int LANES  = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              REQ,
  input  logic              WE,
  input  logic [LANES-1:0]  BE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [WAIT_W-1:0] WAIT_STATES,
  input  logic              READY,
  input  logic [DATA_W-1:0] DIN,
  output logic              ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              ERR,
  output logic [ADDR_W-1:0] ADDR_BUF,
  output logic [DATA_W-1:0] DOUT_BUF,
  output logic              RDN_BUF,
  output logic [LANES-1:0]  WRN_BUF,
  output logic              ABUS_OEN,
  output logic              DBUS_OEN
);

  if (((DATA_W % 8) != 0) || (TIMEOUT < 1)) begin : g_bad_param
    $error("bus_cycle_sequencer: DATA_W must be a multiple of 8 and TIMEOUT >= 1");
  end

  bus_state_t        state;
  logic              we_q;
  logic [LANES-1:0]  be_q;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_zero;
  logic              leave;
  logic              timeout;
  logic              accept;

  bus_wait_counter #(.W(WAIT_W)) u_wait (
    .CLK    (CLK),
    .RESETN (RESETN),
    .load   (state == BUS_SETUP),
    .value  (wait_q),
    .dec    (state == BUS_STROBE),
    .zero   (wait_zero)
  );

  assign leave  = (state == BUS_STROBE) && wait_zero && READY;
  assign accept = REQ && ((state == BUS_IDLE) || (state == BUS_HOLD));

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = bus_cnt_width(TIMEOUT);
  logic to_zero;

  // Starts at TIMEOUT-1 so zero is reached in the TIMEOUT-th STROBE cycle.
  bus_wait_counter #(.W(TO_W)) u_timeout (
    .CLK    (CLK),
    .RESETN (RESETN),
    .load   (state == BUS_SETUP),
    .value  (TO_W'(TIMEOUT - 1)),
    .dec    (state == BUS_STROBE),
    .zero   (to_zero)
  );

  assign timeout = (state == BUS_STROBE) && to_zero && !leave;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  // Bus cycle FSM with every bus output registered; a new request may be
  // accepted from IDLE or directly from HOLD for back-to-back cycles.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state    <= BUS_IDLE;
      ACK      <= 1'b0;
      BUSY     <= 1'b0;
      RDN_BUF  <= 1'b1;
      WRN_BUF  <= '1;
      ABUS_OEN <= 1'b1;
      DBUS_OEN <= 1'b1;
      ADDR_BUF <= '0;
      DOUT_BUF <= '0;
      RDATA    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wait_q   <= '0;
`ifdef BUS_TIMEOUT_EN
      ERR      <= 1'b0;
`endif
    end else begin
      ACK <= 1'b0;
      case (state)
        BUS_SETUP: begin
          state <= BUS_STROBE;
          if (we_q) begin
            WRN_BUF <= ~be_q;
          end else begin
            RDN_BUF <= 1'b0;
          end
        end
        BUS_STROBE: begin
          if (leave || timeout) begin
            state   <= BUS_HOLD;
            ACK     <= 1'b1;
            RDN_BUF <= 1'b1;
            WRN_BUF <= '1;
            if (leave && !we_q) begin
              RDATA <= DIN;
            end
`ifdef BUS_TIMEOUT_EN
            if (timeout) begin
              ERR <= 1'b1;
            end
`endif
          end
        end
        BUS_HOLD: begin
          if (!REQ) begin
            state    <= BUS_IDLE;
            BUSY     <= 1'b0;
            ABUS_OEN <= 1'b1;
            DBUS_OEN <= 1'b1;
          end
        end
        default: ;
      endcase

      if (accept) begin
        state    <= BUS_SETUP;
        BUSY     <= 1'b1;
        ABUS_OEN <= 1'b0;
        DBUS_OEN <= ~WE;
        ADDR_BUF <= ADDR;
        we_q     <= WE;
        be_q     <= BE;
        wait_q   <= WAIT_STATES;
        if (WE) begin
          DOUT_BUF <= WDATA;
        end
`ifdef BUS_TIMEOUT_EN
        ERR      <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: the driver pushes the expected
// outcome of each bus cycle, the monitor pops it on every ACK.
module tb_bus_cycle_sequencer;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WAIT_W  = 3;
  localparam int TIMEOUT = 8;
  localparam int LANES   = 2;

  logic              CLK;
  logic              RESETN;
  logic              REQ;
  logic              WE;
  logic [LANES-1:0]  BE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic [WAIT_W-1:0] WAIT_STATES;
  logic              READY;
  logic [DATA_W-1:0] DIN;
  logic              ACK;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
  logic              ERR;
  logic [ADDR_W-1:0] ADDR_BUF;
  logic [DATA_W-1:0] DOUT_BUF;
  logic              RDN_BUF;
  logic [LANES-1:0]  WRN_BUF;
  logic              ABUS_OEN;
  logic              DBUS_OEN;

  bus_cycle_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .WE(WE), .BE(BE), .ADDR(ADDR),
    .WDATA(WDATA), .WAIT_STATES(WAIT_STATES), .READY(READY), .DIN(DIN),
    .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .ERR(ERR), .ADDR_BUF(ADDR_BUF),
    .DOUT_BUF(DOUT_BUF), .RDN_BUF(RDN_BUF), .WRN_BUF(WRN_BUF),
    .ABUS_OEN(ABUS_OEN), .DBUS_OEN(DBUS_OEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          strobe_len;
    logic        err;
    logic        b2b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_rdata = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: strobe length is the longer of the wait-state count
  // and the READY delay, clipped by the timeout when that feature is built in.
  task automatic issue(input logic we, input logic [1:0] be, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] din,
                       input logic [2:0] ws, input int r, input logic b2b);
    exp_t e;
    int   k;
    bit   done;
    e.we = we; e.be = be; e.addr = addr; e.wdata = wdata; e.b2b = b2b; e.err = 1'b0;
    e.strobe_len = (int'(ws) > r) ? int'(ws) + 1 : r + 1;
`ifdef BUS_TIMEOUT_EN
    if (e.strobe_len > TIMEOUT) begin
      e.strobe_len = TIMEOUT;
      e.err = 1'b1;
    end
`endif
    if (!we && !e.err) model_rdata = din;
    e.rdata = model_rdata;
    sb.push_back(e);
    REQ = 1'b1; WE = we; BE = be; ADDR = addr; WDATA = wdata; WAIT_STATES = ws;
    READY = 1'($urandom); DIN = 16'($urandom);
    k = 0; done = 0;
    while (!done) begin
      @(posedge CLK); #1; k++;
      if (ACK) begin
        done = 1;
      end else if (k > 100) begin
        checks++; errors++;
        $display("FAIL ack_wait actual=none expected=ack within 100 cycles");
        done = 1;
      end else if (k >= 2) begin
        READY = ((k - 1) > r);
        DIN = din;
      end else begin
        READY = 1'($urandom);
        DIN = 16'($urandom);
      end
    end
  endtask

  task automatic go_idle(input int n);
    REQ = 1'b0; WE = 1'($urandom); BE = 2'($urandom); ADDR = 16'($urandom);
    READY = 1'($urandom); DIN = 16'($urandom);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  int          phase_cnt = 0;
  int          strobe_cnt = 0;
  int          since_ack = 0;
  exp_t        cur;
  logic [1:0]  exp_wrn;
  logic        exp_rdn;

  // Monitor: checks every bus cycle against the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RESETN) begin
      phase_cnt = 0; strobe_cnt = 0; since_ack = 0;
    end else begin
      since_ack++;
      if (ACK) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack actual=1 expected=0");
        end else begin
          cur = sb.pop_front();
          check("phase_len", phase_cnt, 1 + cur.strobe_len);
          check("strobe_len", strobe_cnt, (cur.we && cur.be == 2'b00) ? 0 : cur.strobe_len);
          if (cur.b2b) check("b2b_spacing", since_ack, cur.strobe_len + 2);
          check("hold_addr", ADDR_BUF, cur.addr);
          check("hold_strobes", {RDN_BUF, WRN_BUF}, 3'b111);
          check("hold_abus_oen", ABUS_OEN, 0);
          check("hold_busy", BUSY, 1);
          check("rdata", RDATA, cur.rdata);
          check("err", ERR, cur.err);
          if (cur.we) begin
            check("hold_dout", DOUT_BUF, cur.wdata);
            check("hold_dbus_oen", DBUS_OEN, 0);
          end else begin
            check("hold_dbus_oen", DBUS_OEN, 1);
          end
        end
        phase_cnt = 0; strobe_cnt = 0; since_ack = 0;
      end else if (!ABUS_OEN && sb.size() > 0) begin
        cur = sb[0];
        phase_cnt++;
        check("phase_busy", BUSY, 1);
        check("phase_addr", ADDR_BUF, cur.addr);
        if (cur.we) begin
          check("phase_dout", DOUT_BUF, cur.wdata);
          check("phase_dbus_oen", DBUS_OEN, 0);
        end else begin
          check("phase_dbus_oen", DBUS_OEN, 1);
        end
        if (!RDN_BUF || WRN_BUF != 2'b11) begin
          strobe_cnt++;
          exp_wrn = cur.we ? ~cur.be : 2'b11;
          exp_rdn = cur.we;
          check("strobe_rdn", RDN_BUF, exp_rdn);
          check("strobe_wrn", WRN_BUF, exp_wrn);
        end
      end else if (ABUS_OEN) begin
        check("idle_strobes", {RDN_BUF, WRN_BUF}, 3'b111);
        check("idle_busy", BUSY, 0);
        check("idle_dbus_oen", DBUS_OEN, 1);
      end
    end
  end

  int ack_seen;

  initial begin
    RESETN = 1'b0; REQ = 1'b1; WE = 1'b1; BE = 2'b11; ADDR = 16'hFFFF;
    WDATA = 16'hFFFF; WAIT_STATES = 3'd0; READY = 1'b1; DIN = 16'hFFFF;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ack", ACK, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    check("rst_rdn", RDN_BUF, 1);
    check("rst_wrn", WRN_BUF, 2'b11);
    check("rst_abus_oen", ABUS_OEN, 1);
    check("rst_dbus_oen", DBUS_OEN, 1);
    check("rst_addr", ADDR_BUF, 0);
    check("rst_dout", DOUT_BUF, 0);
    check("rst_rdata", RDATA, 0);
    REQ = 1'b0;
    RESETN = 1'b1;
    go_idle(2);

    // Directed cycles
    issue(1'b0, 2'b11, 16'h1234, 16'h0000, 16'hAF55, 3'd0, 0, 1'b0);
    go_idle(1);
    issue(1'b1, 2'b01, 16'h0020, 16'h00FA, 16'h0000, 3'd2, 0, 1'b0);
    go_idle(2);
    issue(1'b0, 2'b00, 16'h0030, 16'h0000, 16'h5AA5, 3'd1, 4, 1'b0);
    go_idle(1);
    issue(1'b1, 2'b11, 16'h0010, 16'h0055, 16'h0000, 3'd0, 0, 1'b0);
    issue(1'b0, 2'b11, 16'h0010, 16'h0000, 16'h0055, 3'd0, 0, 1'b1);
    go_idle(1);
    issue(1'b1, 2'b00, 16'h0040, 16'hBEEF, 16'h0000, 3'd3, 1, 1'b0);
    go_idle(1);
    // READY stuck low long enough to trip the timeout when it is built in
    issue(1'b0, 2'b11, 16'h0050, 16'h0000, 16'h1357, 3'd0, 20, 1'b0);
    go_idle(1);
    issue(1'b0, 2'b11, 16'h0060, 16'h0000, 16'h2468, 3'd0, 0, 1'b0);
    go_idle(1);

    // Randomized cycles, mixed idle gaps and back-to-back
    begin
      logic b2b_next;
      int   r;
      b2b_next = 1'b0;
      for (int i = 0; i < 150; i++) begin
        r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2));
        issue(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              3'($urandom), r, b2b_next);
        b2b_next = 1'($urandom);
        if (!b2b_next) go_idle(int'($urandom_range(1, 3)));
      end
      if (b2b_next) go_idle(1);
    end
    go_idle(2);

    // Reset in the middle of STROBE discards the cycle without an ACK
    REQ = 1'b1; WE = 1'b0; BE = 2'b11; ADDR = 16'h0ABC; WAIT_STATES = 3'd5; READY = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("mid_rst_pre_rdn", RDN_BUF, 0);
    RESETN = 1'b0; REQ = 1'b0;
    @(posedge CLK); #1;
    check("mid_rst_rdn", RDN_BUF, 1);
    check("mid_rst_abus_oen", ABUS_OEN, 1);
    check("mid_rst_dbus_oen", DBUS_OEN, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_ack", ACK, 0);
    check("mid_rst_rdata", RDATA, 0);
    model_rdata = 16'h0000;
    RESETN = 1'b1;
    ack_seen = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (ACK) ack_seen++;
    end
    check("mid_rst_no_ack", ack_seen, 0);

    issue(1'b0, 2'b10, 16'h7777, 16'h0000, 16'hC3C3, 3'd0, 0, 1'b0);
    go_idle(3);
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
